// File: rtl/div_arb_pkg.sv
// div_arb_pkg
// Shared types and helpers for the divider arbiter slice.
//   state_t        : arbiter/divider sequencing state
//   DIV_DATA_WIDTH : default operand width used by the modules below
//   DIV_LAT        : handshake-to-response latency of a non-zero divide
//   first_from()   : rotating first-one search used for request arbitration
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_LAT        = DIV_DATA_WIDTH + 1;

  // Widest request vector first_from() can search.
  localparam int MAX_REQ   = 32;
  localparam int MAX_REQ_W = 5;

  // One-hot of the first set bit of req[n-1:0], starting at index ptr and
  // wrapping back to 0. ptr must be below n. Returns all zeros if no bit set.
  function automatic logic [MAX_REQ-1:0] first_from(
    input logic [MAX_REQ-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    logic [MAX_REQ-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if ((i < n) && !found && req[idx[MAX_REQ_W-1:0]]) begin
        pick[idx[MAX_REQ_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/div_arbiter_core.sv
// div_core
// Sequential signed restoring divider, one quotient bit per step.
//   start     : latch operand magnitudes and signs, arm the step counter
//   step      : perform one restoring iteration
//   dividend  : signed dividend sampled on start
//   divisor   : signed divisor sampled on start
//   div_zero  : divisor input is zero (combinational, valid with start)
//   last      : the current step is the final one
//   quotient  : signed quotient (truncated toward zero), updated on the
//               final step or on a divide-by-zero start, held otherwise
//   remainder : signed remainder, sign follows the dividend
module div_core
  import div_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         step,
  input  logic signed [DATA_WIDTH-1:0] dividend,
  input  logic signed [DATA_WIDTH-1:0] divisor,
  output logic                         div_zero,
  output logic                         last,
  output logic signed [DATA_WIDTH-1:0] quotient,
  output logic signed [DATA_WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  // -2^(W-1) negates to itself, which read unsigned is the right magnitude.
  function automatic logic [DATA_WIDTH-1:0] magnitude(
    input logic signed [DATA_WIDTH-1:0] v
  );
    return v[DATA_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] apply_sign(
    input logic [DATA_WIDTH-1:0] mag,
    input logic                  neg
  );
    logic signed [DATA_WIDTH-1:0] s;
    s = $signed(mag);
    return neg ? -s : s;
  endfunction

  logic [DATA_WIDTH-1:0] quo_p0;    // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] den_p0;
  logic [DATA_WIDTH-1:0] rem_p0;
  logic                  q_sign_p0;
  logic                  r_sign_p0;
  logic [CNT_W-1:0]      cnt;

  logic [DATA_WIDTH:0]   rem_sh;
  logic [DATA_WIDTH:0]   rem_diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] rem_nxt;
  logic [DATA_WIDTH-1:0] quo_nxt;

  assign div_zero = (divisor == '0);
  assign last     = (cnt == '0);

  // Restoring step: the borrow out of the trial subtraction decides the
  // quotient bit, so no separate magnitude compare is needed.
  assign rem_sh   = {rem_p0, quo_p0[DATA_WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, den_p0};
  assign ge       = ~rem_diff[DATA_WIDTH];
  assign rem_nxt  = ge ? rem_diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
  assign quo_nxt  = {quo_p0[DATA_WIDTH-2:0], ge};

  // Stage p0: operand latch and iteration state
  always_ff @(posedge clock) begin
    if (start) begin
      quo_p0    <= magnitude(dividend);
      den_p0    <= magnitude(divisor);
      rem_p0    <= '0;
      q_sign_p0 <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
      r_sign_p0 <= dividend[DATA_WIDTH-1];
    end else if (step) begin
      quo_p0    <= quo_nxt;
      rem_p0    <= rem_nxt;
    end
  end

  // Result registers: written from the final step so they are valid in the
  // cycle that follows it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      cnt <= CNT_W'(DATA_WIDTH - 1);
      if (div_zero) begin
        quotient  <= '0;
        remainder <= dividend;
      end
    end else if (step) begin
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient  <= apply_sign(quo_nxt, q_sign_p0);
        remainder <= apply_sign(rem_nxt, r_sign_p0);
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
// Shares one sequential signed divider between NUM_REQ requesters.
//   clock, reset  : system clock, asynchronous active-high reset
//   req_valid     : per-requester request
//   req_dividend  : packed operands, slice k belongs to requester k
//   req_divisor   : packed operands, slice k belongs to requester k
//   req_ready     : one-hot grant, only while idle; handshake = valid & ready
//   rsp_valid     : one-cycle pulse to the requester that owns the result
//   rsp_quotient  : signed quotient, held until the next result
//   rsp_remainder : signed remainder, held until the next result
//   busy          : an operation is in flight (through the response cycle)
// Build option DIV_ARB_FIXED_PRIO_EN: lowest index always wins and the
// round-robin pointer is not built. Default is round-robin.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int NUM_REQ    = 2,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_divisor,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic signed [DATA_WIDTH-1:0]    rsp_quotient,
  output logic signed [DATA_WIDTH-1:0]    rsp_remainder,
  output logic                            busy
);

  state_t                       state;
  state_t                       state_next;
  logic [ID_W-1:0]              id_p0;
  logic [MAX_REQ-1:0]           pick_full;
  logic                         unused_pick;
  logic [NUM_REQ-1:0]           grant;
  logic                         hs;
  logic [ID_W-1:0]              grant_id;
  logic signed [DATA_WIDTH-1:0] sel_dividend;
  logic signed [DATA_WIDTH-1:0] sel_divisor;
  logic                         core_div_zero;
  logic                         core_last;

`ifdef DIV_ARB_FIXED_PRIO_EN
  assign pick_full = first_from(MAX_REQ'(req_valid), 32'd0, 32'(NUM_REQ));
`else
  logic [ID_W-1:0] rr_ptr;
  assign pick_full = first_from(MAX_REQ'(req_valid), 32'(rr_ptr), 32'(NUM_REQ));
`endif

  assign grant       = pick_full[NUM_REQ-1:0];
  assign unused_pick = ^pick_full;

  assign req_ready = ((state == IDLE) && !reset) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign busy      = (state != IDLE);

  always_comb begin
    grant_id     = '0;
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        grant_id     = ID_W'(k);
        sel_dividend = req_dividend[k*DATA_WIDTH +: DATA_WIDTH];
        sel_divisor  = req_divisor[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  div_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (hs),
    .step      (state == BUSY),
    .dividend  (sel_dividend),
    .divisor   (sel_divisor),
    .div_zero  (core_div_zero),
    .last      (core_last),
    .quotient  (rsp_quotient),
    .remainder (rsp_remainder)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (hs) state_next = core_div_zero ? DONE : BUSY;
      BUSY: if (core_last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (id_p0 == ID_W'(k)) rsp_valid[k] = (state == DONE);
    end
  end

  // Stage p0: sequencing state and owner of the in-flight operation
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      id_p0 <= '0;
    end else begin
      state <= state_next;
      if (hs) id_p0 <= grant_id;
    end
  end

`ifndef DIV_ARB_FIXED_PRIO_EN
  // Search restarts just above the requester that was served last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (state == DONE) begin
      rr_ptr <= (id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : id_p0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
// Self-checking bench for div_arbiter (DATA_WIDTH=32, NUM_REQ=2).
// Jobs are queued per requester; a driver presents them, a monitor moves each
// handshaken job into a response scoreboard and checks the response pulse.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int W = 32;
  localparam int N = 2;

  logic                 clock;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N*W-1:0]       req_dividend;
  logic [N*W-1:0]       req_divisor;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         rsp_valid;
  logic signed [W-1:0]  rsp_quotient;
  logic signed [W-1:0]  rsp_remainder;
  logic                 busy;

  typedef struct {
    int           id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  typedef struct {
    vec_t v;
    int   hs;
  } exp_t;

  vec_t jobq [N][$];
  exp_t expq [$];
  int   hs_log [$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  vec_t tbl [12];
  int   exp_order [4];

  div_arbiter #(
    .DATA_WIDTH (W),
    .NUM_REQ    (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .busy          (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int id, input int a, input int b, input int q, input int r);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.q = q; v.r = r;
    return v;
  endfunction

  // Reference: truncating signed divide; caller avoids b==0 and MIN/-1.
  function automatic vec_t mk_model(input int id, input int a, input int b);
    return mk(id, a, b, a / b, a % b);
  endfunction

  // Driver: present the head job of each requester after every edge.
  initial begin
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    forever begin
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++) begin
        if (jobq[k].size() > 0) begin
          req_valid[k]              = 1'b1;
          req_dividend[k*W +: W]    = jobq[k][0].a;
          req_divisor[k*W +: W]     = jobq[k][0].b;
        end else begin
          req_valid[k] = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard push on handshake, pop and compare on response.
  initial begin
    exp_t e;
    exp_t ex;
    forever begin
      @(negedge clock);
      if (reset) begin
        expq.delete();
      end else begin
        if (busy) check("ready_while_busy", W'(req_ready), '0);
        if (rsp_valid != '0) begin
          if (expq.size() == 0) begin
            check("unexpected_rsp", W'(rsp_valid), '0);
          end else begin
            e = expq.pop_front();
            check("rsp_valid_owner", W'(rsp_valid), W'(1) << e.v.id);
            check("quotient", rsp_quotient, e.v.q);
            check("remainder", rsp_remainder, e.v.r);
            check("latency", W'(cyc - e.hs), W'((e.v.b == '0) ? 1 : DIV_LAT));
            check("busy_in_rsp", W'(busy), W'(1));
          end
        end
        for (int k = 0; k < N; k++) begin
          if (req_valid[k] && req_ready[k] && (jobq[k].size() > 0)) begin
            ex.v  = jobq[k].pop_front();
            ex.hs = cyc;
            expq.push_back(ex);
            hs_log.push_back(k);
          end
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (((jobq[0].size() > 0) || (jobq[1].size() > 0) || (expq.size() > 0) || busy)
           && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", W'(n >= budget), '0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, W'(busy), '0);
    check({tag, "_rsp_valid"}, W'(rsp_valid), '0);
    check({tag, "_req_ready"}, W'(req_ready), '0);
    check({tag, "_quotient"}, rsp_quotient, '0);
    check({tag, "_remainder"}, rsp_remainder, '0);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_state("pulse_rst");
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    #2 reset = 1'b1;

    tbl[0]  = mk(0, 100, 7, 14, 2);
    tbl[1]  = mk(1, -100, 7, -14, -2);
    tbl[2]  = mk(0, 100, -7, -14, 2);
    tbl[3]  = mk(0, 5, 0, 0, 5);
    tbl[4]  = mk(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
    tbl[5]  = mk(0, -7, 0, 0, -7);
    tbl[6]  = mk(1, 32'h80000000, 2, 32'hC0000000, 0);
    tbl[7]  = mk(0, 32'h7FFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF);
    tbl[8]  = mk(1, 32'h80000000, 32'h80000000, 1, 0);
    tbl[9]  = mk(1, -1, 3, 0, -1);
    tbl[10] = mk(0, 1000, -33, -30, 10);
    tbl[11] = mk(1, -1000, -33, 30, -10);

`ifdef DIV_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    @(negedge clock);
    check_reset_state("init_rst");
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      jobq[tbl[i].id].push_back(tbl[i]);
      wait_idle(200);
    end

    check("hold_quotient", rsp_quotient, tbl[11].q);
    repeat (5) @(negedge clock);
    check("hold_remainder", rsp_remainder, tbl[11].r);

    for (int i = 0; i < 8; i++) begin
      int a;
      int b;
      a = int'($urandom);
      b = int'($urandom_range(2, 5000));
      if (i % 2 == 1) b = -b;
      jobq[i % 2].push_back(mk_model(i % 2, a, b));
      wait_idle(200);
    end

    // Both requesters pending continuously.
    pulse_reset();
    hs_log.delete();
    jobq[0].push_back(mk(0, 8, 2, 4, 0));
    jobq[0].push_back(mk(0, 8, 2, 4, 0));
    jobq[1].push_back(mk(1, 9, 3, 3, 0));
    jobq[1].push_back(mk(1, 9, 3, 3, 0));
    wait_idle(500);
    check("grant_count", W'(hs_log.size()), W'(4));
    for (int k = 0; (k < 4) && (k < hs_log.size()); k++) begin
      check($sformatf("grant_order_%0d", k), W'(hs_log[k]), W'(exp_order[k]));
    end

    // Reset in the middle of a divide drops it; a later request is normal.
    jobq[0].push_back(mk(0, 1000, 3, 333, 1));
    repeat (10) @(posedge clock);
    #1 reset = 1'b1;
    jobq[1].push_back(mk(1, 10, 3, 3, 1));
    @(posedge clock);
    @(negedge clock);
    check("midop_rst_busy", W'(busy), '0);
    check("midop_rst_rsp_valid", W'(rsp_valid), '0);
    check("midop_rst_req_ready", W'(req_ready), '0);
    check("midop_rst_quotient", rsp_quotient, '0);
    @(posedge clock);
    #1 reset = 1'b0;
    wait_idle(300);
    if (hs_log.size() > 0) check("post_rst_grant", W'(hs_log[$]), W'(1));
    else check("post_rst_grant_seen", '0, W'(1));
    check("post_rst_quotient", rsp_quotient, W'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one sequential signed restoring divider between NUM_REQ requesters, for example the FM demod angle-ratio stage and other fixed-point datapath stages.
- Replaces the per-stage combinational divide loop with one multi-cycle resource.
- Round-robin arbitration with a valid/ready request handshake and a one-cycle response pulse per requester.
- Exactly one division is in flight at a time.

Parameters:
- DATA_WIDTH, 32, operand/result width (two's-complement signed).
- NUM_REQ, 2, number of requesters (≥1).
- ID_W, $clog2(NUM_REQ) (min 1), requester index width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_dividend  in  NUM_REQ*DATA_WIDTH  packed; slice k belongs to requester k
- req_divisor  in  NUM_REQ*DATA_WIDTH  packed; slice k belongs to requester k
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
- rsp_valid  out  NUM_REQ  one-cycle pulse to the owning requester
- rsp_quotient  out  DATA_WIDTH  signed quotient, truncated toward zero
- rsp_remainder  out  DATA_WIDTH  signed remainder; sign follows the dividend
- busy  out  1  high from grant until the response cycle, inclusive

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Reset values: state IDLE, rr_ptr=0, rsp_valid=0, rsp_quotient=0, rsp_remainder=0, busy=0.
- req_ready is forced 0 while reset is high.
- Any in-flight operation is dropped on reset; no response is ever issued for it.
- State IDLE:
  - req_ready is combinational: one-hot on the first asserted req_valid, searching from rr_ptr upward with wrap.
  - On a handshake, latch |dividend| and |divisor| as unsigned DATA_WIDTH values, plus q_sign = sign(dividend)^sign(divisor), r_sign = sign(dividend), and id.
  - Divisor==0: go to DONE.
  - Divisor≠0: go to BUSY with cnt=DATA_WIDTH-1.
- State BUSY:
  - One restoring step per cycle: shift the partial remainder left by one and bring in the dividend MSB.
  - If partial remainder ≥ divisor, subtract it and shift in q-bit 1; otherwise shift in 0.
  - Exit to DONE after DATA_WIDTH steps (cnt==0).
  - req_ready=0 for all requesters.
- State DONE:
  - Register rsp_quotient = q_sign ? -q : q and rsp_remainder = r_sign ? -r : r.
  - Pulse rsp_valid[id] for exactly one cycle.
  - rr_ptr ← (id+1) mod NUM_REQ; go to IDLE.
  - req_ready=0 in this state.
- Latency, from the handshake cycle at edge 0:
  - Normal divide: rsp_valid is high in cycle DATA_WIDTH+1.
  - Divide-by-zero: rsp_valid is high in cycle 1, with quotient=0 and remainder=dividend.
  - Throughput: one operation per DATA_WIDTH+2 cycles.
- Overflow: (-2^(W-1)) / (-1) gives quotient 0x80..0 (wraps) and remainder 0.
  - -2^(W-1) as a dividend is handled via its unsigned magnitude.
- rsp_quotient and rsp_remainder hold their value until the next DONE.
- rsp_valid carries no backpressure; the requester must sample it in the pulse cycle.
- A requester keeps req_valid and its operands stable until handshake.
- A requester that drops req_valid before grant is simply skipped.
- Simultaneous requests: exactly one grant per IDLE cycle. The losers stay pending and are granted in later rounds in rotating order, so no requester starves.
- Requests arriving during BUSY or DONE wait; the earliest possible grant is the cycle after DONE.

Optional Feature:
- Macro: DIV_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, with the lowest index winning; rr_ptr is not instantiated.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package div_arb_pkg:
  - state_t enum {IDLE, BUSY, DONE}
  - localparam DIV_LAT = DATA_WIDTH+1
  - function for the rotating first-one search
- Sub-module div_core:
  - start/done interface containing the abs/sign latch, the restoring iteration and the sign fix-up.
- div_arbiter keeps the arbitration, rr_ptr, id tracking and response demux.

Test Plan:
- Requester 0: 100 / 7 → rsp_valid[0] in cycle 33, quotient=14, remainder=2; rsp_valid[1] stays 0.
- Requester 1: -100 / 7 → quotient=-14, remainder=-2. Requester 0: 100 / -7 → quotient=-14, remainder=2.
- Requester 0: 5 / 0 → rsp_valid[0] in cycle 1, quotient=0, remainder=5.
- Both requesters valid continuously with 8/2 and 9/3 → grants alternate 0,1,0,1; responses 4 and 3 alternate.
  - With DIV_ARB_FIXED_PRIO_EN defined, requester 0 is granted every time.
- 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Reset asserted in cycle 10 of a 1000/3 operation → no rsp_valid, busy=0. After release, a new 10/3 request → quotient=3, remainder=1 with normal latency.
